// File: rtl/ibex_pkg_pext.sv
// Shared type definitions for the packed-SIMD (Zpn) multiply unit.
// The final enumerator stands in for any decoded Zpn operator this unit does not implement.
package ibex_pkg_pext;

  typedef enum logic [4:0] {
    ZpnSmbb16,
    ZpnSmbt16,
    ZpnSmtt16,
    ZpnKmda,
    ZpnKmxda,
    ZpnSmds,
    ZpnSmxds,
    ZpnSmdrs,
    ZpnKmabb,
    ZpnKmabt,
    ZpnKmatt,
    ZpnKmada,
    ZpnKmaxda,
    ZpnKmads,
    ZpnKmaxds,
    ZpnKmadrs,
    ZpnKmsda,
    ZpnKmsxda,
    ZpnOther
  } zpn_op_e;

endpackage

// File: rtl/ibex_pext_mul16.sv
// Fixed-latency 16x16 signed multiply / multiply-accumulate unit for Zpn operators.
// SingleMult selects one shared multiplier (serial lanes) or two (parallel lanes).
module ibex_pext_mul16
  import ibex_pkg_pext::*;
#(
  parameter bit SingleMult = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  zpn_op_e     operator_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rd_i,
  input  logic        kill_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic        ov_o
);

  typedef enum logic [1:0] {StIdle, StMul0, StMul1, StAcc} state_e;
  typedef enum logic [2:0] {SelNone, SelBB, SelBT, SelTT, SelDA, SelXDA} sel_e;

  state_e             state_q, state_d;
  zpn_op_e            op_q;
  logic [31:0]        a_q, b_q, c_q;
  logic signed [32:0] p0_q, p1_q;
  logic               valid_q, ov_q;
  logic [31:0]        result_q;
  logic               accept, mul0_en, mul1_en, acc_en;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; kill from any busy state returns to idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StMul0;
      StMul0:  state_d = SingleMult ? StMul1 : StAcc;
      StMul1:  state_d = StAcc;
      StAcc:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (kill_i) state_d = StIdle;
  end

  // Per-state outputs and enables
  always_comb begin
    ready_o = (state_q == StIdle);
    accept  = ready_o & valid_i & ~kill_i;
    mul0_en = (state_q == StMul0) & ~kill_i;
    mul1_en = (state_q == StMul1) & ~kill_i;
    acc_en  = (state_q == StAcc) & ~kill_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q <= ZpnOther;
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
    end else if (accept) begin
      op_q <= operator_i;
      a_q  <= rs1_i;
      b_q  <= rs2_i;
      c_q  <= rd_i;
    end
  end

  sel_e               sel;
  logic signed [16:0] a_lo, a_hi, b_lo, b_hi;
  logic signed [16:0] x0, y0, x1, y1;

  assign a_lo = {a_q[15], a_q[15:0]};
  assign a_hi = {a_q[31], a_q[31:16]};
  assign b_lo = {b_q[15], b_q[15:0]};
  assign b_hi = {b_q[31], b_q[31:16]};

  always_comb begin
    sel = SelNone;
    unique case (op_q)
      ZpnSmbb16, ZpnKmabb: sel = SelBB;
      ZpnSmbt16, ZpnKmabt: sel = SelBT;
      ZpnSmtt16, ZpnKmatt: sel = SelTT;
      ZpnKmda, ZpnSmds, ZpnSmdrs, ZpnKmada, ZpnKmads, ZpnKmadrs, ZpnKmsda: sel = SelDA;
      ZpnKmxda, ZpnSmxds, ZpnKmaxda, ZpnKmaxds, ZpnKmsxda:               sel = SelXDA;
      default: sel = SelNone;
    endcase
  end

  // Lane operands: (x0*y0) forms p0, (x1*y1) forms p1
  always_comb begin
    x0 = '0;
    y0 = '0;
    x1 = '0;
    y1 = '0;
    unique case (sel)
      SelBB: begin x0 = a_lo; y0 = b_lo; end
      SelBT: begin x0 = a_lo; y0 = b_hi; end
      SelTT: begin x0 = a_hi; y0 = b_hi; end
      SelDA: begin x0 = a_hi; y0 = b_hi; x1 = a_lo; y1 = b_lo; end
      SelXDA: begin x0 = a_hi; y0 = b_lo; x1 = a_lo; y1 = b_hi; end
      default: ;
    endcase
  end

  if (SingleMult) begin : g_serial
    logic signed [16:0] mul_x, mul_y;
    logic signed [32:0] prod;

    assign mul_x = (state_q == StMul1) ? x1 : x0;
    assign mul_y = (state_q == StMul1) ? y1 : y0;
    assign prod  = 33'(mul_x) * 33'(mul_y);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        p0_q <= '0;
        p1_q <= '0;
      end else begin
        if (mul0_en) p0_q <= prod;
        if (mul1_en) p1_q <= prod;
      end
    end
  end else begin : g_parallel
    logic signed [32:0] prod0, prod1;

    assign prod0 = 33'(x0) * 33'(y0);
    assign prod1 = 33'(x1) * 33'(y1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        p0_q <= '0;
        p1_q <= '0;
      end else if (mul0_en) begin
        p0_q <= prod0;
        p1_q <= prod1;
      end
    end
  end

  logic signed [34:0] p0_x, p1_x, c_x, sum;
  logic               sat_en;
  logic [31:0]        result_d;
  logic               ov_d;

  assign p0_x = 35'(p0_q);
  assign p1_x = 35'(p1_q);
  assign c_x  = 35'($signed(c_q));

  always_comb begin
    sum    = '0;
    sat_en = 1'b0;
    unique case (op_q)
      ZpnSmbb16, ZpnSmbt16, ZpnSmtt16: sum = p0_x;
      ZpnKmda, ZpnKmxda:               begin sum = p0_x + p1_x; sat_en = 1'b1; end
      ZpnSmds, ZpnSmxds:               sum = p0_x - p1_x;
      ZpnSmdrs:                        sum = p1_x - p0_x;
      ZpnKmabb, ZpnKmabt, ZpnKmatt:    begin sum = c_x + p0_x; sat_en = 1'b1; end
      ZpnKmada, ZpnKmaxda:             begin sum = c_x + p0_x + p1_x; sat_en = 1'b1; end
      ZpnKmads, ZpnKmaxds:             begin sum = c_x + p0_x - p1_x; sat_en = 1'b1; end
      ZpnKmadrs:                       begin sum = c_x + p1_x - p0_x; sat_en = 1'b1; end
      ZpnKmsda, ZpnKmsxda:             begin sum = c_x - p0_x - p1_x; sat_en = 1'b1; end
      default: ;
    endcase
  end

  // Out of 32-bit range when the bits above bit 31 are not a pure sign extension
  always_comb begin
    result_d = sum[31:0];
    ov_d     = 1'b0;
    if (sat_en) begin
      if (!sum[34] && (sum[33:31] != 3'b000)) begin
        result_d = 32'h7FFF_FFFF;
        ov_d     = 1'b1;
      end else if (sum[34] && (sum[33:31] != 3'b111)) begin
        result_d = 32'h8000_0000;
        ov_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      ov_q     <= 1'b0;
    end else begin
      valid_q <= acc_en;
      if (acc_en) begin
        result_q <= result_d;
        ov_q     <= ov_d;
      end
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign ov_o     = ov_q;

endmodule

// File: tb/tb_ibex_pext_mul16.sv
// Bench for ibex_pext_mul16: serial and parallel instances against an arithmetic reference model.
module tb_ibex_pext_mul16;
  import ibex_pkg_pext::*;

  localparam longint SatMax = 64'sd2147483647;
  localparam longint SatMin = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  zpn_op_e     op = ZpnOther;
  logic [31:0] rs1 = '0, rs2 = '0, rd = '0;
  logic        v_s = 1'b0, k_s = 1'b0, v_p = 1'b0, k_p = 1'b0;
  logic        rdy_s, vo_s, ov_s, rdy_p, vo_p, ov_p;
  logic [31:0] res_s, res_p;
  int          tests = 0;
  int          fails = 0;

  ibex_pext_mul16 #(.SingleMult(1'b1)) u_ser (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_s), .operator_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .rd_i(rd), .kill_i(k_s), .ready_o(rdy_s), .valid_o(vo_s), .result_o(res_s), .ov_o(ov_s)
  );

  ibex_pext_mul16 #(.SingleMult(1'b0)) u_par (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_p), .operator_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .rd_i(rd), .kill_i(k_p), .ready_o(rdy_p), .valid_o(vo_p), .result_o(res_p), .ov_o(ov_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Returns {ov, result} computed straight from the operator definitions
  function automatic logic [32:0] model(input zpn_op_e o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    longint ab = longint'($signed(a[15:0]));
    longint at = longint'($signed(a[31:16]));
    longint bb = longint'($signed(b[15:0]));
    longint bt = longint'($signed(b[31:16]));
    longint cc = longint'($signed(c));
    longint s;
    bit     k;
    case (o)
      ZpnSmbb16: begin s = ab * bb; k = 0; end
      ZpnSmbt16: begin s = ab * bt; k = 0; end
      ZpnSmtt16: begin s = at * bt; k = 0; end
      ZpnKmda:   begin s = at * bt + ab * bb; k = 1; end
      ZpnKmxda:  begin s = at * bb + ab * bt; k = 1; end
      ZpnSmds:   begin s = at * bt - ab * bb; k = 0; end
      ZpnSmxds:  begin s = at * bb - ab * bt; k = 0; end
      ZpnSmdrs:  begin s = ab * bb - at * bt; k = 0; end
      ZpnKmabb:  begin s = cc + ab * bb; k = 1; end
      ZpnKmabt:  begin s = cc + ab * bt; k = 1; end
      ZpnKmatt:  begin s = cc + at * bt; k = 1; end
      ZpnKmada:  begin s = cc + at * bt + ab * bb; k = 1; end
      ZpnKmaxda: begin s = cc + at * bb + ab * bt; k = 1; end
      ZpnKmads:  begin s = cc + at * bt - ab * bb; k = 1; end
      ZpnKmaxds: begin s = cc + at * bb - ab * bt; k = 1; end
      ZpnKmadrs: begin s = cc + ab * bb - at * bt; k = 1; end
      ZpnKmsda:  begin s = cc - at * bt - ab * bb; k = 1; end
      ZpnKmsxda: begin s = cc - at * bb - ab * bt; k = 1; end
      default:   return 33'd0;
    endcase
    if (k && s > SatMax) return {1'b1, 32'h7FFF_FFFF};
    if (k && s < SatMin) return {1'b1, 32'h8000_0000};
    return {1'b0, s[31:0]};
  endfunction

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 4))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_acc();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    op  = zpn_op_e'(5'($urandom_range(0, 18)));
    rs1 = $urandom;
    rs2 = $urandom;
    rd  = $urandom;
  endtask

  // Issue one op to both instances and check result, flag, latency and pulse count
  task automatic issue_both(input string tag, input zpn_op_e o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c);
    logic [32:0] expv;
    int          lat_s = 0, lat_p = 0, cnt_s = 0, cnt_p = 0;
    logic [31:0] r_s = '0, r_p = '0;
    logic        o_s = 1'b0, o_p = 1'b0;
    expv = model(o, a, b, c);
    op = o; rs1 = a; rs2 = b; rd = c;
    v_s = 1'b1; v_p = 1'b1;
    step();
    v_s = 1'b0; v_p = 1'b0;
    scramble();
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (vo_s) begin cnt_s++; lat_s = cyc; r_s = res_s; o_s = ov_s; end
      if (vo_p) begin cnt_p++; lat_p = cyc; r_p = res_p; o_p = ov_p; end
      step();
    end
    chk({tag, " ser latency"}, 32'(lat_s), 32'd4);
    chk({tag, " ser pulses"}, 32'(cnt_s), 32'd1);
    chk({tag, " ser result"}, r_s, expv[31:0]);
    chk({tag, " ser ov"}, 32'(o_s), 32'(expv[32]));
    chk({tag, " par latency"}, 32'(lat_p), 32'd3);
    chk({tag, " par pulses"}, 32'(cnt_p), 32'd1);
    chk({tag, " par result"}, r_p, expv[31:0]);
    chk({tag, " par ov"}, 32'(o_p), 32'(expv[32]));
  endtask

  initial begin
    logic [32:0] ex1, ex2, ex3;
    int          cnt_s, cnt_p;
    logic [31:0] cap;

    #2 rst_n = 1'b0;
    #1;
    chk("reset ser valid", 32'(vo_s), 32'd0);
    chk("reset ser result", res_s, 32'd0);
    chk("reset ser ov", 32'(ov_s), 32'd0);
    chk("reset ser ready", 32'(rdy_s), 32'd1);
    chk("reset par valid", 32'(vo_p), 32'd0);
    chk("reset par result", res_p, 32'd0);
    chk("reset par ready", 32'(rdy_p), 32'd1);
    step(); step();
    rst_n = 1'b1;
    step();

    issue_both("smbb16", ZpnSmbb16, 32'h0003_FFFE, 32'h0007_0005, 32'h0);
    issue_both("kmda sat", ZpnKmda, 32'h8000_8000, 32'h8000_8000, 32'h0);
    issue_both("kmsda sat", ZpnKmsda, 32'h0001_0001, 32'h0001_0001, 32'h8000_0000);
    issue_both("kmada", ZpnKmada, 32'h0002_0003, 32'h0004_0005, 32'd10);
    issue_both("other op", ZpnOther, 32'h1234_5678, 32'h9ABC_DEF0, 32'h5555_5555);

    for (int i = 0; i < 30; i++) begin
      issue_both("random", zpn_op_e'(5'($urandom_range(0, 18))), {rand_lane(), rand_lane()},
                 {rand_lane(), rand_lane()}, rand_acc());
    end

    // Back-to-back on the serial instance: second request in the valid_o cycle
    op = ZpnSmdrs; rs1 = 32'h0100_0040; rs2 = 32'h0200_0300; rd = 32'h0;
    ex1 = model(op, rs1, rs2, rd);
    v_s = 1'b1;
    step();
    v_s = 1'b0;
    scramble();
    step(); step(); step();
    op = ZpnKmaxds; rs1 = 32'h7FFF_8000; rs2 = 32'h7FFF_7FFF; rd = 32'h4000_0000;
    ex2 = model(op, rs1, rs2, rd);
    v_s = 1'b1;
    @(negedge clk);
    chk("b2b first valid", 32'(vo_s), 32'd1);
    chk("b2b ready with valid", 32'(rdy_s), 32'd1);
    chk("b2b first result", res_s, ex1[31:0]);
    step();
    v_s = 1'b0;
    scramble();
    @(negedge clk);
    chk("b2b gap valid", 32'(vo_s), 32'd0);
    chk("b2b busy ready", 32'(rdy_s), 32'd0);
    step(); step(); step();
    @(negedge clk);
    chk("b2b second valid", 32'(vo_s), 32'd1);
    chk("b2b second result", res_s, ex2[31:0]);
    chk("b2b second ov", 32'(ov_s), 32'(ex2[32]));
    step();

    // Kill in MUL1 of the serial instance
    op = ZpnSmds; rs1 = 32'h0011_0022; rs2 = 32'h0033_0044; rd = 32'h0;
    v_s = 1'b1;
    step();
    v_s = 1'b0;
    step();
    k_s = 1'b1;
    step();
    k_s = 1'b0;
    @(negedge clk);
    chk("kill ready next", 32'(rdy_s), 32'd1);
    cnt_s = 0;
    for (int i = 0; i < 6; i++) begin
      if (vo_s) cnt_s++;
      step();
      @(negedge clk);
    end
    chk("kill no valid", 32'(cnt_s), 32'd0);
    chk("kill result held", res_s, ex2[31:0]);
    chk("kill ov held", 32'(ov_s), 32'(ex2[32]));
    step();
    issue_both("smtt16 after kill", ZpnSmtt16, 32'h0003_0000, 32'h0003_0000, 32'h0);

    // Kill while idle blocks acceptance
    op = ZpnKmda; rs1 = 32'h0005_0005; rs2 = 32'h0005_0005; rd = 32'h0;
    v_s = 1'b1; v_p = 1'b1; k_s = 1'b1; k_p = 1'b1;
    step();
    v_s = 1'b0; v_p = 1'b0; k_s = 1'b0; k_p = 1'b0;
    @(negedge clk);
    chk("idle kill ser ready", 32'(rdy_s), 32'd1);
    chk("idle kill par ready", 32'(rdy_p), 32'd1);
    cnt_s = 0; cnt_p = 0;
    for (int i = 0; i < 6; i++) begin
      if (vo_s) cnt_s++;
      if (vo_p) cnt_p++;
      step();
      @(negedge clk);
    end
    chk("idle kill ser no valid", 32'(cnt_s), 32'd0);
    chk("idle kill par no valid", 32'(cnt_p), 32'd0);
    step();

    // valid_i held while busy is ignored
    op = ZpnSmbt16; rs1 = 32'h0000_0003; rs2 = 32'h0007_0000; rd = 32'h0;
    ex3 = model(op, rs1, rs2, rd);
    v_s = 1'b1;
    step();
    op = ZpnKmda; rs1 = $urandom; rs2 = $urandom;
    @(negedge clk);
    chk("busy ready low", 32'(rdy_s), 32'd0);
    step(); step(); step();
    v_s = 1'b0;
    cnt_s = 0;
    cap = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vo_s) begin cnt_s++; cap = res_s; end
      step();
    end
    chk("busy single valid", 32'(cnt_s), 32'd1);
    chk("busy result", cap, ex3[31:0]);

    // Reset asserted while the serial instance is in MUL1
    op = ZpnKmda; rs1 = 32'h0100_0100; rs2 = 32'h0100_0100; rd = 32'h0;
    v_s = 1'b1; v_p = 1'b1;
    step();
    v_s = 1'b0; v_p = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midop reset ser result", res_s, 32'd0);
    chk("midop reset ser ov", 32'(ov_s), 32'd0);
    chk("midop reset ser valid", 32'(vo_s), 32'd0);
    chk("midop reset ser ready", 32'(rdy_s), 32'd1);
    chk("midop reset par result", res_p, 32'd0);
    step();
    rst_n = 1'b1;
    cnt_s = 0; cnt_p = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vo_s) cnt_s++;
      if (vo_p) cnt_p++;
      step();
    end
    chk("after reset ser no valid", 32'(cnt_s), 32'd0);
    chk("after reset par no valid", 32'(cnt_p), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ibex_pext_mul16.md
IBEX_PEXT_MUL16 -- requirements
Module: ibex_pext_mul16

Interface
REQ-001 SHALL have parameter SingleMult, default 1'b1. 1 = one shared 17x17 signed multiplier computing the two lane products serially; 0 = two multipliers computing them in parallel.
REQ-002 clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 valid_i  input  1  operation request from the decode/issue stage.
REQ-005 operator_i  input  ibex_pkg_pext::zpn_op_e  decoded P-ext operator.
REQ-006 rs1_i  input  32  operand a; a.B = [15:0], a.T = [31:16], both signed.
REQ-007 rs2_i  input  32  operand b; same lane layout as a.
REQ-008 rd_i  input  32  accumulator c, the old rd value, signed.
REQ-009 kill_i  input  1  flush; aborts any in-flight operation.
REQ-010 ready_o  output  1  block can accept a request.
REQ-011 valid_o  output  1  one-cycle pulse; result_o and ov_o are valid.
REQ-012 result_o  output  32  rd write data.
REQ-013 ov_o  output  1  saturation occurred; feeds the vxsat/OV flag.

Function
REQ-014 SHALL use an FSM with states IDLE, MUL0, MUL1, ACC; ready_o = (state == IDLE).
REQ-015 Acceptance SHALL occur when valid_i & ready_o & ~kill_i; operator and all operands are registered on acceptance.
REQ-016 State transitions SHALL be:
- IDLE -> MUL0 on acceptance.
- MUL0 -> MUL1 if SingleMult = 1, otherwise MUL0 -> ACC.
- MUL1 -> ACC.
- ACC -> IDLE.
REQ-017 Product registers SHALL be 33-bit signed.
- SingleMult = 1: MUL0 computes p0 and stores it; MUL1 computes p1 and stores it.
- SingleMult = 0: MUL0 computes and stores both p0 and p1.
REQ-018 Lane product selection (p0, p1) SHALL be:
- BB: (a.B*b.B, 0)
- BT: (a.B*b.T, 0)
- TT: (a.T*b.T, 0)
- DA: (a.T*b.T, a.B*b.B)
- XDA: (a.T*b.B, a.B*b.T)
REQ-019 In ACC the block SHALL compute a 35-bit signed sum s, register result_o and ov_o, and set valid_o = 1 for the following cycle, in which the FSM is already IDLE.
REQ-020 Formulas for s:
- SMBB16/SMBT16/SMTT16 = p0.
- KMDA/KMXDA = p0+p1.
- SMDS/SMXDS = p0-p1.
- SMDRS = p1-p0.
- KMABB/KMABT/KMATT = c+p0.
- KMADA/KMAXDA = c+p0+p1.
- KMADS/KMAXDS = c+p0-p1.
- KMADRS = c+p1-p0.
- KMSDA/KMSXDA = c-p0-p1.
REQ-021 K-prefixed operators SHALL saturate s to [0x80000000, 0x7FFFFFFF] and set ov_o = 1 only when clamping occurs. SM-prefixed operators SHALL output s[31:0] with ov_o = 0.
REQ-022 Any operator outside REQ-020 SHALL be accepted and complete with the same latency, result_o = 0 and ov_o = 0.
REQ-023 Latency SHALL be fixed: valid_o at cycle N+4 (SingleMult = 1) or N+3 (SingleMult = 0) after acceptance at cycle N. Output has no backpressure.
REQ-024 valid_o SHALL be low in every cycle other than the one after ACC; result_o and ov_o hold their last value between completions.
REQ-025 A new request SHALL be acceptable in the same cycle valid_o is high, giving back-to-back throughput of one op per 4 (or 3) cycles.
REQ-026 kill_i in MUL0, MUL1 or ACC SHALL force IDLE next cycle and suppress valid_o; result_o and ov_o are not updated.
REQ-027 kill_i in IDLE SHALL block acceptance that cycle and have no other effect.
REQ-028 valid_i while not ready_o SHALL be ignored; the request is not queued.

Reset
REQ-029 While rst_ni is low, the following SHALL take their reset values immediately, independent of clk_i:
- state = IDLE, valid_o = 0, result_o = 0, ov_o = 0, product registers = 0, ready_o = 1.
REQ-030 Reset asserted mid-operation SHALL discard the operation; no valid_o is produced after release.

Verification
REQ-031 SMBB16, a = 0x0003FFFE, b = 0x00070005 -> result_o = 0xFFFFFFF6, ov_o = 0, valid_o exactly at N+4.
REQ-032 KMDA, a = b = 0x80008000 -> sum = 2^31 -> result_o = 0x7FFFFFFF, ov_o = 1.
REQ-033 KMSDA, c = 0x80000000, a = b = 0x00010001 -> result_o = 0x80000000, ov_o = 1.
REQ-034 SingleMult = 0, KMADA, c = 10, a = 0x00020003, b = 0x00040005 -> result_o = 0x00000021, ov_o = 0, valid_o at N+3.
REQ-035 Kill and reset cases:
- SMDS accepted at N, kill_i = 1 at N+2 -> no valid_o, ready_o = 1 at N+3; a following SMTT16 with a = b = 0x00030000 returns 0x00000009.
- rst_ni low during MUL1 -> outputs zero immediately; after release, no valid_o.
